// File: rtl/sdram_seq_pkg.sv
// Shared definitions for the SDRAM command sequencer: phase codes,
// the phase enum and the width of the per-phase timer.
package sdram_seq_pkg;

    localparam int TIMER_W = 8;

    localparam logic [2:0] PH_PRE  = 3'b000;
    localparam logic [2:0] PH_ACT  = 3'b001;
    localparam logic [2:0] PH_WCMD = 3'b010;
    localparam logic [2:0] PH_RCMD = 3'b011;
    localparam logic [2:0] PH_DATA = 3'b100;
    localparam logic [2:0] PH_WREC = 3'b101;
    localparam logic [2:0] PH_IDLE = 3'b111;

    // 3'b110 has no member; the FSM treats it as illegal and recovers to IDLE.
    typedef enum logic [2:0] {
        PRE  = PH_PRE,
        ACT  = PH_ACT,
        WCMD = PH_WCMD,
        RCMD = PH_RCMD,
        DATA = PH_DATA,
        WREC = PH_WREC,
        IDLE = PH_IDLE
    } phase_t;

endpackage

// File: rtl/sdram_cmd_sequencer_if.sv
// Request handshake and bank-side control bundle of the SDRAM command
// sequencer. The front end / bench uses the master modport, the sequencer
// uses the slave modport.
interface sdram_cmd_sequencer_if
    import sdram_seq_pkg::*;
#(
    parameter int ROW_W = 12
);
    logic               ReqValid;
    logic               ReqRw;
    logic [ROW_W-1:0]   ReqRow;
    logic               ReqReady;
    logic               BusStall;
    logic [2:0]         LdState;
    logic               TimerLd;
    logic [TIMER_W-1:0] TimerCount;
    logic               RwState;
    logic               BusySignal;
    logic               Done;

    modport master (
        output ReqValid, ReqRw, ReqRow, BusStall,
        input  ReqReady, LdState, TimerLd, TimerCount, RwState, BusySignal, Done
    );

    modport slave (
        input  ReqValid, ReqRw, ReqRow, BusStall,
        output ReqReady, LdState, TimerLd, TimerCount, RwState, BusySignal, Done
    );

endinterface

// File: rtl/sdram_phase_timer.sv
// Loadable down-counter timing each sequencer phase. Load wins over hold;
// the count parks at zero until the next load.
module sdram_phase_timer
    import sdram_seq_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               hold,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    // Count register: load at phase entry, otherwise decrement unless held.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!hold && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: walks one request at a time through
// PRE -> ACT -> RCMD/WCMD -> DATA (-> WREC) and drives the bank-side bundle.
// Optional feature: define SDRAM_OPEN_ROW_EN to keep the row open after a
// transaction and skip PRE/ACT for a request to that same row.
module sdram_cmd_sequencer
    import sdram_seq_pkg::*;
#(
    parameter int T_RP      = 2,
    parameter int T_RCD     = 2,
    parameter int CAS_LAT   = 2,
    parameter int BURST_LEN = 4,
    parameter int T_WR      = 2,
    parameter int ROW_W     = 12
)(
    input  logic                 Clk,
    input  logic                 Reset,
    sdram_cmd_sequencer_if.slave bus
);

    phase_t             state;
    phase_t             next_state;
    logic               rw_q;
    logic               timer_ld_q;
    logic               timer_load;
    logic               timer_hold;
    logic               timer_zero;
    logic [TIMER_W-1:0] timer_count;
    logic [TIMER_W-1:0] load_value;
    logic               accept;
    logic               row_hit;
    logic               done;

    // Timer load value for the first cycle of a phase; a phase lasts load+1 cycles.
    function automatic logic [TIMER_W-1:0] phase_load(input phase_t ph);
        case (ph)
            PRE:     return TIMER_W'(T_RP - 1);
            ACT:     return TIMER_W'(T_RCD - 1);
            RCMD:    return TIMER_W'(CAS_LAT - 1);
            DATA:    return TIMER_W'(BURST_LEN);
            WREC:    return TIMER_W'(T_WR - 1);
            default: return '0;
        endcase
    endfunction

    assign accept = (state == IDLE) && bus.ReqValid;

`ifdef SDRAM_OPEN_ROW_EN
    logic [ROW_W-1:0] open_row_q;
    logic             row_valid_q;

    // Open-row tracking: row latched on accept, marked valid once the transaction completes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            open_row_q  <= '0;
            row_valid_q <= 1'b0;
        end else if (accept) begin
            open_row_q  <= bus.ReqRow;
            row_valid_q <= 1'b0;
        end else if (done) begin
            row_valid_q <= 1'b1;
        end
    end

    assign row_hit = row_valid_q && (bus.ReqRow == open_row_q);
`else
    assign row_hit = 1'b0;
`endif

    // Next-phase decode and timer control.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would infer a latch.
        next_state = state;
        case (state)
            IDLE: if (bus.ReqValid)
                      next_state = row_hit ? (bus.ReqRw ? WCMD : RCMD) : PRE;
            PRE:  if (timer_zero) next_state = ACT;
            ACT:  if (timer_zero) next_state = rw_q ? WCMD : RCMD;
            WCMD: if (timer_zero) next_state = DATA;
            RCMD: if (timer_zero) next_state = DATA;
            DATA: if (timer_zero && !bus.BusStall) next_state = rw_q ? WREC : IDLE;
            WREC: if (timer_zero) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        timer_load = (next_state != state);
        load_value = phase_load(next_state);
        timer_hold = (state == DATA) && bus.BusStall;
    end

    // Phase register, phase-entry pulse and latched direction.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            timer_ld_q <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state      <= next_state;
            timer_ld_q <= timer_load && (next_state != IDLE);
            if (accept) rw_q <= bus.ReqRw;
        end
    end

    sdram_phase_timer u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (timer_load),
        .load_value (load_value),
        .hold       (timer_hold),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    // A stalled final DATA cycle is not the final cycle, so Done waits for it.
    assign done = timer_zero &&
                  (((state == DATA) && !bus.BusStall && !rw_q) || (state == WREC));

    assign bus.LdState    = state;
    assign bus.TimerLd    = timer_ld_q;
    assign bus.TimerCount = timer_count;
    assign bus.RwState    = rw_q;
    assign bus.BusySignal = (state == DATA) && bus.BusStall;
    assign bus.Done       = done;
    assign bus.ReqReady   = (state == IDLE);

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Self-checking bench for sdram_cmd_sequencer: table of transactions whose
// per-cycle expectations go through a scoreboard queue, plus hand-written
// reset-abort and back-to-back sequences. Honours SDRAM_OPEN_ROW_EN.
module tb_sdram_cmd_sequencer;

    localparam int T_RP      = 2;
    localparam int T_RCD     = 2;
    localparam int CAS_LAT   = 2;
    localparam int BURST_LEN = 4;
    localparam int T_WR      = 2;
    localparam int ROW_W     = 12;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 Clk = ~Clk;

    sdram_cmd_sequencer_if #(.ROW_W(ROW_W)) bus ();

    sdram_cmd_sequencer #(
        .T_RP(T_RP), .T_RCD(T_RCD), .CAS_LAT(CAS_LAT),
        .BURST_LEN(BURST_LEN), .T_WR(T_WR), .ROW_W(ROW_W)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] ld;
        logic       tld;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       ready;
        logic       stall;
    } exp_t;

    typedef struct {
        bit             rw;
        logic [11:0]    row;
        bit             skip;
        int             stall_cnt;
        int             stall_len;
        int             exp_done;
    } vec_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected cycles of one phase: count load..0, stall cycles inserted at stall_cnt.
    task automatic push_phase(input logic [2:0] ph, input int load, input bit is_data,
                              input int stall_cnt, input int stall_len, input bit done_last);
        exp_t e;
        for (int c = load; c >= 0; c--) begin
            if (is_data && c == stall_cnt) begin
                for (int s = 0; s < stall_len; s++) begin
                    e = '{ld: ph, tld: (c == load && s == 0), cnt: 8'(c), busy: 1'b1,
                          done: 1'b0, ready: 1'b0, stall: 1'b1};
                    sb.push_back(e);
                end
            end
            e = '{ld: ph, tld: (c == load) && !(is_data && c == stall_cnt && stall_len > 0),
                  cnt: 8'(c), busy: 1'b0, done: done_last && (c == 0), ready: 1'b0, stall: 1'b0};
            sb.push_back(e);
        end
    endtask

    task automatic build_expected(input bit rw, input bit skip, input int sc, input int sl);
        exp_t e;
        if (!skip) begin
            push_phase(3'b000, T_RP - 1, 1'b0, -1, 0, 1'b0);
            push_phase(3'b001, T_RCD - 1, 1'b0, -1, 0, 1'b0);
        end
        if (rw) push_phase(3'b010, 0, 1'b0, -1, 0, 1'b0);
        else    push_phase(3'b011, CAS_LAT - 1, 1'b0, -1, 0, 1'b0);
        push_phase(3'b100, BURST_LEN, 1'b1, sc, sl, !rw);
        if (rw) push_phase(3'b101, T_WR - 1, 1'b0, -1, 0, 1'b1);
        e = '{ld: 3'b111, tld: 1'b0, cnt: 8'd0, busy: 1'b0, done: 1'b0, ready: 1'b1, stall: 1'b0};
        sb.push_back(e);
    endtask

    // One full transaction: accept in cycle 0, then pop and compare each cycle.
    task automatic run_txn(input string name, input vec_t v);
        exp_t e;
        int   cyc;
        int   done_at;
        sb.delete();
        build_expected(v.rw, v.skip, v.stall_cnt, v.stall_len);
        bus.ReqValid = 1'b1;
        bus.ReqRw    = v.rw;
        bus.ReqRow   = v.row;
        bus.BusStall = 1'b0;
        #1;
        check({name, " accept ready"}, 32'(bus.ReqReady), 32'd1);
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
        cyc = 1;
        done_at = -1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.BusStall = e.stall;
            #1;
            check($sformatf("%s c%0d LdState", name, cyc), 32'(bus.LdState), 32'(e.ld));
            check($sformatf("%s c%0d TimerLd", name, cyc), 32'(bus.TimerLd), 32'(e.tld));
            check($sformatf("%s c%0d TimerCount", name, cyc), 32'(bus.TimerCount), 32'(e.cnt));
            check($sformatf("%s c%0d BusySignal", name, cyc), 32'(bus.BusySignal), 32'(e.busy));
            check($sformatf("%s c%0d Done", name, cyc), 32'(bus.Done), 32'(e.done));
            check($sformatf("%s c%0d ReqReady", name, cyc), 32'(bus.ReqReady), 32'(e.ready));
            if (e.ld != 3'b111)
                check($sformatf("%s c%0d RwState", name, cyc), 32'(bus.RwState), 32'(v.rw));
            if (bus.Done === 1'b1) done_at = cyc;
            @(posedge Clk); #1;
            cyc++;
        end
        bus.BusStall = 1'b0;
        check({name, " done cycle"}, 32'(done_at), 32'(v.exp_done));
    endtask

    vec_t vecs[8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   acc_cyc[2];
        int   done_cyc[$];
        int   idx;
        bit   rws[2];
        vec_t rv;

        // Transactions with the Done cycle taken from the timing description.
        vecs[0] = '{rw: 1'b0, row: 12'h001, skip: 1'b0, stall_cnt: -1, stall_len: 0, exp_done: 11};
        vecs[1] = '{rw: 1'b1, row: 12'h002, skip: 1'b0, stall_cnt: -1, stall_len: 0, exp_done: 12};
        vecs[2] = '{rw: 1'b0, row: 12'h003, skip: 1'b0, stall_cnt: 2,  stall_len: 2, exp_done: 13};
        vecs[3] = '{rw: 1'b1, row: 12'h004, skip: 1'b0, stall_cnt: BURST_LEN, stall_len: 1, exp_done: 13};
        vecs[4] = '{rw: 1'b0, row: 12'h007, skip: 1'b0, stall_cnt: 0,  stall_len: 3, exp_done: 14};
        vecs[5] = '{rw: 1'b0, row: 12'h005, skip: 1'b0, stall_cnt: -1, stall_len: 0, exp_done: 11};
`ifdef SDRAM_OPEN_ROW_EN
        vecs[6] = '{rw: 1'b1, row: 12'h005, skip: 1'b1, stall_cnt: -1, stall_len: 0, exp_done: 8};
`else
        vecs[6] = '{rw: 1'b1, row: 12'h005, skip: 1'b0, stall_cnt: -1, stall_len: 0, exp_done: 12};
`endif
        vecs[7] = '{rw: 1'b0, row: 12'h006, skip: 1'b0, stall_cnt: -1, stall_len: 0, exp_done: 11};

        bus.ReqValid = 1'b0;
        bus.ReqRw    = 1'b0;
        bus.ReqRow   = '0;
        bus.BusStall = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        // Reset state, with BusStall high to show it is ignored outside DATA.
        check("reset LdState", 32'(bus.LdState), 32'h7);
        check("reset TimerCount", 32'(bus.TimerCount), 32'h0);
        check("reset TimerLd", 32'(bus.TimerLd), 32'h0);
        check("reset RwState", 32'(bus.RwState), 32'h0);
        check("reset Done", 32'(bus.Done), 32'h0);
        check("reset ReqReady", 32'(bus.ReqReady), 32'h1);
        check("reset BusySignal", 32'(bus.BusySignal), 32'h0);
        bus.BusStall = 1'b0;

        for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Reset asserted during ACT aborts the read with no Done.
        bus.ReqValid = 1'b1;
        bus.ReqRw    = 1'b0;
        bus.ReqRow   = 12'h033;
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("abort in ACT", 32'(bus.LdState), 32'h1);
        Reset = 1'b0;
        #1;
        check("abort LdState", 32'(bus.LdState), 32'h7);
        check("abort TimerCount", 32'(bus.TimerCount), 32'h0);
        check("abort Done", 32'(bus.Done), 32'h0);
        #2;
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("after abort LdState", 32'(bus.LdState), 32'h7);
        check("after abort Done", 32'(bus.Done), 32'h0);
        rv = '{rw: 1'b0, row: 12'h033, skip: 1'b0, stall_cnt: -1, stall_len: 0, exp_done: 11};
        run_txn("post-abort read", rv);

        // Back-to-back: ReqValid held high until both requests are accepted.
        rws[0] = 1'b0;
        rws[1] = 1'b1;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        idx = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            bus.ReqValid = (idx < 2);
            bus.ReqRw    = rws[idx % 2];
            bus.ReqRow   = (idx == 0) ? 12'h010 : 12'h020;
            bus.BusStall = 1'b0;
            #1;
            if (bus.Done === 1'b1) done_cyc.push_back(cyc);
            if (bus.ReqValid && bus.ReqReady === 1'b1) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(posedge Clk); #1;
        end
        bus.ReqValid = 1'b0;
        check("b2b first accept", 32'(acc_cyc[0]), 32'd0);
        check("b2b second accept", 32'(acc_cyc[1]), 32'd12);
        check("b2b done count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) begin
            check("b2b first done", 32'(done_cyc[0]), 32'd11);
            check("b2b second done", 32'(done_cyc[1]), 32'd24);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
